// File: rtl/reaction_ctrl_if.sv
// Bus between the reaction-timer sequencer and its peripherals: the buttons,
// the delay generator and the scoring unit.
//
// Every transfer here is a strobe, not a valid/ready pair. dly_ld and
// sc_update are each high for exactly one clock and are never back-pressured.
// The receiver must act on any cycle where the strobe is high. sc_data is
// stable in that same cycle and holds its value until the next sc_update.
//
// dbg_state mirrors the sequencer FSM state so that checkers can bind to it.
interface reaction_ctrl_if;
  logic        start;
  logic        react;
  logic        dly_done;
  logic        dly_ld;
  logic        dly_en;
  logic        led;
  logic [15:0] sc_data;
  logic        sc_update;
  logic        busy;
  logic        cheat;
  logic [2:0]  dbg_state;

  // The sequencer: it reads the buttons and the delay expiry, and drives everything else.
  modport master (
    input  start, react, dly_done,
    output dly_ld, dly_en, led, sc_data, sc_update, busy, cheat, dbg_state
  );

  // The environment: the buttons, the delay generator and the scoring unit.
  modport slave (
    output start, react, dly_done,
    input  dly_ld, dly_en, led, sc_data, sc_update, busy, cheat, dbg_state
  );
endinterface

// File: rtl/reaction_ctrl.sv
// Reaction-timer sequencer.
// A start press loads and runs the random delay, then lights the stimulus LED.
// The sequencer then times the response in BCD milliseconds and writes the
// result to the scoring unit. A press before the LED lights is flagged as a
// cheat.
// Optional feature macro: CHEAT_PENALTY_EN. When it is defined, a cheat also
// writes 16'h9999 to the scoring unit.
module reaction_ctrl #(
  parameter int TICK_DIV = 50000,
  parameter int TICK_W   = 16
) (
  input logic           clk,
  input logic           reset,
  reaction_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WAIT   = 3'd2,
    S_TIMING = 3'd3,
    S_REPORT = 3'd4,
    S_CHEAT  = 3'd5
  } state_t;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [15:0]       BCD_MAX   = 16'h9999;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_start_q;
  logic              r_start_prev;
  logic              r_react_q;
  logic              r_react_prev;
  logic              w_start_pe;
  logic              w_react_pe;
  logic [TICK_W-1:0] r_presc;
  logic              w_tick;
  logic [15:0]       r_bcd;
  logic [15:0]       w_bcd_inc;
  logic [15:0]       w_bcd_nxt;
  logic              w_carry;
  logic [15:0]       r_sc_data;
  logic              r_cheat;
  logic              w_dly_ld;
  logic              w_dly_en;
  logic              w_led;
  logic              w_sc_update;

  // Register the buttons. The previous-value registers reset to 1, so a
  // button that is held while reset is released does not count as a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_start_q    <= 1'b1;
      r_start_prev <= 1'b1;
      r_react_q    <= 1'b1;
      r_react_prev <= 1'b1;
    end else begin
      r_start_q    <= bus.start;
      r_start_prev <= r_start_q;
      r_react_q    <= bus.react;
      r_react_prev <= r_react_q;
    end
  end

  assign w_start_pe = r_start_q & ~r_start_prev;
  assign w_react_pe = r_react_q & ~r_react_prev;
  assign w_tick     = (r_state == S_TIMING) && (r_presc == TICK_LAST);

  // Add one to the BCD counter with a decimal carry that ripples through the nibbles.
  always_comb begin
    w_bcd_inc = r_bcd;
    w_carry   = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (w_carry) begin
        if (r_bcd[4*d +: 4] == 4'd9) begin
          w_bcd_inc[4*d +: 4] = 4'd0;
        end else begin
          w_bcd_inc[4*d +: 4] = r_bcd[4*d +: 4] + 4'd1;
          w_carry             = 1'b0;
        end
      end
    end
  end

  // The count value for the next cycle: it advances on a tick and saturates at 9999.
  assign w_bcd_nxt = (w_tick && (r_bcd != BCD_MAX)) ? w_bcd_inc : r_bcd;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic and the Moore strobes/enables.
  always_comb begin
    w_state_nxt = r_state;
    w_dly_ld    = 1'b0;
    w_dly_en    = 1'b0;
    w_led       = 1'b0;
    w_sc_update = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_pe) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        // dly_done may still show the previous run's expiry, so it is ignored here.
        w_dly_ld    = 1'b1;
        w_dly_en    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_dly_en = 1'b1;
        if (w_react_pe)        w_state_nxt = S_CHEAT;
        else if (bus.dly_done) w_state_nxt = S_TIMING;
      end
      S_TIMING: begin
        w_led = 1'b1;
        if (w_react_pe) w_state_nxt = S_REPORT;
      end
      S_REPORT: begin
        w_sc_update = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_CHEAT: begin
`ifdef CHEAT_PENALTY_EN
        w_sc_update = 1'b1;
`endif
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Millisecond prescaler and BCD counter. Both are cleared when the LED lights.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
      r_bcd   <= '0;
    end else if ((r_state == S_WAIT) && (w_state_nxt == S_TIMING)) begin
      r_presc <= '0;
      r_bcd   <= '0;
    end else if (r_state == S_TIMING) begin
      r_presc <= w_tick ? '0 : r_presc + TICK_W'(1);
      r_bcd   <= w_bcd_nxt;
    end
  end

  // Score register. It is loaded on entry to the write cycle, so the data is
  // valid in the same cycle as sc_update. A tick in the react cycle is included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sc_data <= '0;
    end else if ((r_state == S_TIMING) && (w_state_nxt == S_REPORT)) begin
      r_sc_data <= w_bcd_nxt;
    end
`ifdef CHEAT_PENALTY_EN
    else if ((r_state == S_WAIT) && (w_state_nxt == S_CHEAT)) begin
      r_sc_data <= BCD_MAX;
    end
`endif
  end

  // Cheat flag: it is set by the CHEAT cycle and cleared by the next accepted start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              r_cheat <= 1'b0;
    else if ((r_state == S_IDLE) && w_start_pe) r_cheat <= 1'b0;
    else if (r_state == S_CHEAT)             r_cheat <= 1'b1;
  end

  assign bus.dly_ld    = w_dly_ld;
  assign bus.dly_en    = w_dly_en;
  assign bus.led       = w_led;
  assign bus.sc_data   = r_sc_data;
  assign bus.sc_update = w_sc_update;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.cheat     = r_cheat;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl with TICK_DIV=4.
// The bench models the delay generator itself. The expected score is derived
// from the game's timeline: the press is registered, then detected as an edge,
// then reported. So the LED is lit for k+2 cycles after the bench waits k
// cycles, and the score is floor((k+2)/4) in BCD, saturating at 9999.
module tb_reaction_ctrl;
  localparam int DIV = 4;

  logic clk;
  logic reset;
  reaction_ctrl_if bus();

  reaction_ctrl #(.TICK_DIV(DIV), .TICK_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  logic [15:0] last_data;

  // Delay-generator model: loaded on dly_ld, counts down while enabled.
  int unsigned dg_cnt;
  int unsigned dg_load;
  always @(posedge clk or negedge reset) begin
    if (!reset)                          dg_cnt <= 0;
    else if (bus.dly_ld)                 dg_cnt <= dg_load;
    else if (bus.dly_en && dg_cnt != 0)  dg_cnt <= dg_cnt - 1;
  end
  assign bus.dly_done = (dg_cnt == 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every sc_update must match the oldest expected write.
  always @(negedge clk) begin
    if (reset && bus.sc_update === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_sc_update: got data %0h expected no write", bus.sc_data);
      end else begin
        chk("scoreboard_sc_data", {16'h0, bus.sc_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // Reference: a number of milliseconds converted to 4-digit BCD, saturating at 9999.
  function automatic logic [15:0] to_bcd(input int ms);
    int v;
    v = (ms > 9999) ? 9999 : ms;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: press start and check the LOAD strobe. Returns at the first WAIT cycle.
  task automatic begin_game(input int L);
    dg_load   = L;
    bus.start = 1'b1;
    tick();
    chk("preload_busy", bus.busy, 0);
    tick();
    chk("load_dly_ld", bus.dly_ld, 1);
    chk("load_dly_en", bus.dly_en, 1);
    chk("load_cheat_cleared", bus.cheat, 0);
    bus.start = 1'b0;
    tick();
    chk("wait_dly_ld_one_cycle", bus.dly_ld, 0);
    chk("wait_dly_en", bus.dly_en, 1);
    chk("wait_led", bus.led, 0);
  endtask

  // Driver: wait for the LED. WAIT should last L+1 cycles.
  task automatic wait_led(input int L);
    int n;
    n = 0;
    while (!bus.led && n < 2000) begin
      n++;
      tick();
    end
    chk("wait_length", n, L + 1);
    chk("timing_dly_en", bus.dly_en, 0);
  endtask

  // Driver: press react now, then check the REPORT cycle and the return to IDLE.
  task automatic finish_normal(input logic [15:0] exp_data);
    int n;
    bus.react = 1'b1;
    exp_q.push_back(exp_data);
    n = 0;
    while (!bus.sc_update && n < 50) begin
      n++;
      tick();
    end
    chk("react_latency", n, 2);
    chk("report_sc_data", {16'h0, bus.sc_data}, {16'h0, exp_data});
    chk("report_led", bus.led, 0);
    chk("report_busy", bus.busy, 1);
    bus.react = 1'b0;
    tick();
    chk("idle_sc_update", bus.sc_update, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_sc_data_held", {16'h0, bus.sc_data}, {16'h0, exp_data});
    chk("idle_cheat", bus.cheat, 0);
    last_data = exp_data;
  endtask

  // Driver: press react k cycles into WAIT. The edge lands in WAIT when k+1 <= L.
  task automatic do_cheat(input int k);
    repeat (k) tick();
    bus.react = 1'b1;
`ifdef CHEAT_PENALTY_EN
    exp_q.push_back(16'h9999);
    last_data = 16'h9999;
`endif
    tick();
    chk("cheat_edge_led", bus.led, 0);
    tick();
    chk("cheat_busy", bus.busy, 1);
    chk("cheat_led", bus.led, 0);
    chk("cheat_dly_en", bus.dly_en, 0);
`ifdef CHEAT_PENALTY_EN
    chk("cheat_sc_update", bus.sc_update, 1);
`else
    chk("cheat_sc_update", bus.sc_update, 0);
`endif
    chk("cheat_sc_data", {16'h0, bus.sc_data}, {16'h0, last_data});
    bus.react = 1'b0;
    tick();
    chk("cheat_flag", bus.cheat, 1);
    chk("cheat_idle_busy", bus.busy, 0);
    tick();
  endtask

  typedef struct {
    int          L;
    bit          is_cheat;
    int          k;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int L;
    int k;
    bit c;

    vecs[0] = '{L: 10, is_cheat: 0, k: 40,  exp_data: 16'h0010};
    vecs[1] = '{L: 3,  is_cheat: 0, k: 0,   exp_data: 16'h0000};
    vecs[2] = '{L: 1,  is_cheat: 0, k: 2,   exp_data: 16'h0001};
    vecs[3] = '{L: 5,  is_cheat: 0, k: 37,  exp_data: 16'h0009};
    vecs[4] = '{L: 10, is_cheat: 1, k: 9,   exp_data: 16'h0000};  // react edge coincides with dly_done
    vecs[5] = '{L: 0,  is_cheat: 0, k: 398, exp_data: 16'h0100};
    vecs[6] = '{L: 8,  is_cheat: 1, k: 2,   exp_data: 16'h0000};
    vecs[7] = '{L: 6,  is_cheat: 0, k: 38,  exp_data: 16'h0010};

    // Reset with both buttons held.
    reset     = 1'b0;
    bus.start = 1'b1;
    bus.react = 1'b1;
    last_data = 16'h0000;
    #3;
    chk("rst_busy", bus.busy, 0);
    chk("rst_led", bus.led, 0);
    chk("rst_dly_ld", bus.dly_ld, 0);
    chk("rst_dly_en", bus.dly_en, 0);
    chk("rst_sc_update", bus.sc_update, 0);
    chk("rst_sc_data", {16'h0, bus.sc_data}, 0);
    chk("rst_cheat", bus.cheat, 0);
    #20 reset = 1'b1;
    tick();
    repeat (4) begin
      chk("held_start_busy", bus.busy, 0);
      chk("held_start_dly_ld", bus.dly_ld, 0);
      tick();
    end
    bus.start = 1'b0;
    bus.react = 1'b0;
    repeat (2) tick();

    // Table-driven games.
    for (int i = 0; i < 8; i++) begin
      begin_game(vecs[i].L);
      if (vecs[i].is_cheat) begin
        do_cheat(vecs[i].k);
      end else begin
        wait_led(vecs[i].L);
        repeat (vecs[i].k) tick();
        finish_normal(vecs[i].exp_data);
      end
      tick();
    end

    // A start press during TIMING is ignored: 10 cycles lit, then react.
    begin_game(3);
    wait_led(3);
    repeat (5) tick();
    bus.start = 1'b1;
    repeat (3) begin
      tick();
      chk("start_in_timing_led", bus.led, 1);
      chk("start_in_timing_dly_ld", bus.dly_ld, 0);
    end
    bus.start = 1'b0;
    repeat (2) tick();
    finish_normal(to_bcd((10 + 2) / DIV));
    tick();

    // Randomised games against the reference.
    for (int g = 0; g < 14; g++) begin
      c = ($urandom_range(0, 3) == 0);
      L = $urandom_range(1, 25);
      k = c ? $urandom_range(0, L - 1) : $urandom_range(0, 120);
      begin_game(L);
      if (c) begin
        do_cheat(k);
      end else begin
        wait_led(L);
        repeat (k) tick();
        finish_normal(to_bcd((k + 2) / DIV));
      end
      tick();
    end

    // Saturation at 9999.
    begin_game(2);
    wait_led(2);
    repeat (40004) tick();
    finish_normal(to_bcd((40004 + 2) / DIV));
    tick();

    // Asynchronous reset during TIMING.
    begin_game(4);
    wait_led(4);
    repeat (20) tick();
    reset = 1'b0;
    #1;
    chk("midrst_led", bus.led, 0);
    chk("midrst_sc_data", {16'h0, bus.sc_data}, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_sc_update", bus.sc_update, 0);
    chk("midrst_dly_en", bus.dly_en, 0);
    #15 reset = 1'b1;
    last_data = 16'h0000;
    repeat (5) begin
      tick();
      chk("post_rst_busy", bus.busy, 0);
      chk("post_rst_led", bus.led, 0);
    end

    // A cheat after reset leaves the cleared score alone, or writes the penalty.
    begin_game(6);
    do_cheat(1);
    begin_game(2);
    wait_led(2);
    repeat (13) tick();
    finish_normal(to_bcd((13 + 2) / DIV));
    repeat (3) tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog: stop the run if it does not finish in time.
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reaction_ctrl.md
Name: reaction_ctrl

Overview:
- Reaction-timer sequencer; initiator side of the delay generator and of the scoring unit.
- On a start press it loads and runs the random delay, then lights the stimulus LED.
- It then times the player's response in BCD milliseconds and writes the result to the scoring unit with a one-cycle update strobe.
- Early presses are flagged as cheats.

Parameters:
- TICK_DIV, 50000, clk cycles per millisecond tick (≥2).
- TICK_W, 16, width of the internal tick prescaler (must hold TICK_DIV-1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  start button, synchronous, level.
- react  in  1  reaction button, synchronous, level.
- dly_done  in  1  delay-generator expiry; high while its counter is 0.
- dly_ld  out  1  one-cycle load strobe to the delay generator.
- dly_en  out  1  delay-generator count/LFSR enable.
- led  out  1  stimulus LED.
- sc_data  out  16  4-digit BCD reaction time to the scoring unit (SCin).
- sc_update  out  1  one-cycle write strobe to the scoring unit (SCupdate).
- busy  out  1  high in any state other than IDLE.
- cheat  out  1  early-press flag, held until the next accepted start.

Behaviour:
- Reset (reset=0, async):
  - State = IDLE; all outputs 0; sc_data = 16'h0000; BCD counter and prescaler = 0.
  - Previous-value registers for start/react = 1, so a button held through reset does not create an edge.
- Edge detect: start_pe and react_pe are rising edges of the registered button value versus its previous cycle.
- IDLE:
  - dly_en = 0.
  - start_pe → LOAD; cheat cleared on the same edge.
  - react ignored.
- LOAD:
  - Exactly one cycle; dly_ld = 1, dly_en = 1.
  - dly_done is ignored here because it may be stale.
  - → WAIT.
- WAIT:
  - dly_en = 1, led = 0.
  - react_pe → CHEAT (react has priority over a simultaneous dly_done).
  - Otherwise dly_done = 1 → TIMING, with BCD counter and prescaler cleared on that transition.
- TIMING:
  - led = 1, dly_en = 0.
  - Prescaler increments every cycle and wraps at TICK_DIV-1; the wrap cycle is a tick.
  - Each tick adds 1 to the BCD counter with decimal carry per nibble (0x0009→0x0010, 0x0999→0x1000).
  - Counter saturates at 0x9999 with no wrap; state is held until react.
  - react_pe → REPORT. A tick in the same cycle still counts, so the latched value includes it.
- REPORT:
  - One cycle; sc_data <= BCD counter; sc_update = 1; led = 0.
  - → IDLE.
  - sc_data keeps its value until the next write.
- CHEAT:
  - One cycle; cheat <= 1; led = 0; dly_en = 0; sc_update = 0.
  - → IDLE.
- Latency:
  - start_pe to dly_ld: 1 cycle after the edge-detect register.
  - react_pe to sc_update: 1 cycle.
  - sc_data is valid in the same cycle that sc_update is high.
- start_pe outside IDLE is ignored.
- No state is ever skipped; every path returns to IDLE.
- Reset asserted mid-operation aborts immediately: led off, no sc_update, sc_data cleared.

Optional Feature:
- Macro: CHEAT_PENALTY_EN.
- Defined: the CHEAT state also drives sc_data <= 16'h9999 and sc_update = 1 for that cycle. last_time reads 9999; best_time cannot improve from it.
- Undefined: CHEAT writes nothing; sc_data and sc_update are untouched; only the cheat flag is set.

Test Plan:
- Reset release with start held high → no LOAD and busy=0; release then press start → dly_ld high for exactly 1 cycle, then WAIT with dly_en=1.
- TICK_DIV=4: dly_done after 10 cycles in WAIT, react pressed 40 cycles after led rises → sc_update pulse with sc_data=16'h0010, led=0, state back to IDLE.
- TICK_DIV=4: 400 cycles of timing → count crosses 0x0099→0x0100, sc_data=16'h0100; hold 40004+ cycles → sc_data=16'h9999 (saturated).
- react_pe in WAIT, same cycle as dly_done → cheat=1, led never rises, no sc_update (macro off); with CHEAT_PENALTY_EN, sc_update with sc_data=16'h9999.
- reset pulled low during TIMING → led=0, sc_data=0, busy=0 asynchronously; no sc_update on release.
- start pressed during TIMING → ignored; next start press from IDLE clears cheat and issues dly_ld.
